// File: rtl/axi_burst_reader_if.sv
// AXI4 read address/data channels plus the outgoing word stream of the burst reader.
// master = the burst reader; slave = memory side and stream consumer.
interface axi_burst_reader_if;
    logic [31:0] araddr;
    logic [7:0]  arlen;
    logic [2:0]  arsize;
    logic [1:0]  arburst;
    logic        arlock;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rlast;
    logic        rvalid;
    logic        rready;
    logic [31:0] m_data;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;

    modport master (
        output araddr, arlen, arsize, arburst, arlock, arvalid, rready,
        output m_data, m_valid, m_last,
        input  arready, rdata, rresp, rlast, rvalid, m_ready
    );

    modport slave (
        input  araddr, arlen, arsize, arburst, arlock, arvalid, rready,
        input  m_data, m_valid, m_last,
        output arready, rdata, rresp, rlast, rvalid, m_ready
    );
endinterface

// File: rtl/axi_burst_reader.sv
// AXI4 INCR read-burst sequencer: fetches a contiguous word block, one burst in flight,
// split at MAX_BURST beats and at 4 KB pages, and streams the data out with zero latency.
module axi_burst_reader #(
    parameter int unsigned MAX_BURST = 16
) (
    input  logic                      aclk,
    input  logic                      aresetn,
    input  logic                      start,
    input  logic [31:0]               base_addr,
    input  logic [15:0]               len_words,
    output logic                      busy,
    output logic                      done,
    output logic                      err,
    axi_burst_reader_if.master        bus
);
    localparam logic [1:0] StIdle = 2'd0;
    localparam logic [1:0] StAddr = 2'd1;
    localparam logic [1:0] StData = 2'd2;
    localparam logic [1:0] StFin  = 2'd3;

    logic [1:0]  r_state;
    logic [31:0] r_addr;
    logic [15:0] r_remaining;
    logic [8:0]  r_beat_cnt;
    logic [31:0] r_araddr;
    logic [7:0]  r_arlen;
    logic        r_arvalid;
    logic        r_busy;
    logic        r_done;
    logic        r_err;

    logic [31:0] w_start_addr;
    logic [31:0] w_src_addr;
    logic [15:0] w_src_rem;
    logic [8:0]  w_beats;
    logic [8:0]  w_ar_beats;
    logic        w_in_data;
    logic        w_r_hs;

    // Largest burst that fits the request, MAX_BURST and the rest of the 4 KB page.
    function automatic logic [8:0] calc_beats(input logic [31:0] addr, input logic [15:0] rem);
        logic [12:0] page;
        logic [15:0] n;
        page = (13'd4096 - {1'b0, addr[11:0]}) >> 2;
        n    = (rem < 16'(MAX_BURST)) ? rem : 16'(MAX_BURST);
        if ({3'b000, page} < n) n = {3'b000, page};
        return n[8:0];
    endfunction

    assign w_start_addr = base_addr & ~32'h3;
    assign w_src_addr   = (r_state == StIdle) ? w_start_addr : r_addr;
    assign w_src_rem    = (r_state == StIdle) ? len_words : r_remaining;
    assign w_beats      = calc_beats(w_src_addr, w_src_rem);
    assign w_ar_beats   = {1'b0, r_arlen} + 9'd1;
    assign w_in_data    = (r_state == StData);
    assign w_r_hs       = w_in_data && bus.rvalid && bus.m_ready;

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            r_state     <= StIdle;
            r_addr      <= 32'd0;
            r_remaining <= 16'd0;
            r_beat_cnt  <= 9'd0;
            r_araddr    <= 32'd0;
            r_arlen     <= 8'd0;
            r_arvalid   <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_err       <= 1'b0;
        end else begin
            r_done <= 1'b0;
            case (r_state)
                StIdle: begin
                    if (start) begin
                        r_err  <= 1'b0;
                        r_busy <= 1'b1;
                        if (len_words == 16'd0) begin
                            r_state <= StFin;
                        end else begin
                            r_addr      <= w_start_addr;
                            r_remaining <= len_words;
                            r_araddr    <= w_start_addr;
                            r_arlen     <= 8'(w_beats - 9'd1);
                            r_arvalid   <= 1'b1;
                            r_state     <= StAddr;
                        end
                    end
                end
                StAddr: begin
                    if (bus.arready) begin
                        r_arvalid   <= 1'b0;
                        r_beat_cnt  <= w_ar_beats;
                        r_addr      <= r_addr + {21'd0, w_ar_beats, 2'b00};
                        r_remaining <= r_remaining - {7'd0, w_ar_beats};
                        r_state     <= StData;
                    end
                end
                StData: begin
                    if (w_r_hs) begin
                        r_beat_cnt <= r_beat_cnt - 9'd1;
                        if (bus.rresp != 2'b00) r_err <= 1'b1;
                        if (bus.rlast != (r_beat_cnt == 9'd1)) r_err <= 1'b1;
                        // Our beat count, not rlast, decides where the burst ends.
                        if (r_beat_cnt == 9'd1) begin
                            if (r_remaining != 16'd0) begin
                                r_araddr  <= r_addr;
                                r_arlen   <= 8'(w_beats - 9'd1);
                                r_arvalid <= 1'b1;
                                r_state   <= StAddr;
                            end else begin
                                r_state <= StFin;
                            end
                        end
                    end
                end
                StFin: begin
                    r_done  <= 1'b1;
                    r_busy  <= 1'b0;
                    r_state <= StIdle;
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign bus.araddr  = r_araddr;
    assign bus.arlen   = r_arlen;
    assign bus.arsize  = 3'd2;
    assign bus.arburst = 2'b01;
    assign bus.arlock  = 1'b0;
    assign bus.arvalid = r_arvalid;
    assign bus.rready  = w_in_data && bus.m_ready;
    assign bus.m_valid = w_in_data && bus.rvalid;
    assign bus.m_data  = bus.rdata;
    assign bus.m_last  = w_in_data && bus.rvalid && (r_beat_cnt == 9'd1)
                         && (r_remaining == 16'd0);

    assign busy = r_busy;
    assign done = r_done;
    assign err  = r_err;
endmodule
